// File: rtl/de_pipeline_controller.sv
// Purpose: decode/execute pipeline sequencer (stall, flush, bubble, CALL/RET/INT stack phases).
// Latency: 1 cycle from a taken branch to the first flush; load-use stall is combinational, same cycle.
// Backpressure: holds PC/FD via pc_stall/fd_stall; a branch aborts any sequence, interrupts wait for a clean IDLE.
module de_pipeline_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_call,
  input  logic             dec_ret,
  input  logic [REG_W-1:0] dec_src1,
  input  logic [REG_W-1:0] dec_src2,
  input  logic             dec_use1,
  input  logic             dec_use2,
  input  logic             ex_mr,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             intr_req,
  output logic             pc_stall,
  output logic             fd_stall,
  output logic             fd_flush,
  output logic             de_bubble,
  output logic [1:0]       flash_num,
  output logic [1:0]       first_time_call,
  output logic [1:0]       first_time_ret,
  output logic [1:0]       first_time_int,
  output logic [1:0]       enable_push_pop,
  output logic             int_ack,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, CALL_HI, CALL_LO, RET_HI, RET_LO, RET_WAIT, INT_FLAGS, INT_HI, INT_LO
  } state_t;

  localparam logic [1:0] FLUSH_LD = 2'(FLUSH_CYCLES);
  localparam logic [1:0] PP_NONE  = 2'b00;
  localparam logic [1:0] PP_PUSH  = 2'b01;
  localparam logic [1:0] PP_POP   = 2'b10;

  state_t     state_q, state_d;
  logic [1:0] flush_q, flush_d;
  logic       pend_q, pend_d;
  logic       ack_d;
  logic       load_use_c;
  logic       hazard;
  logic       flush_idle;

  // Moore outputs, registered from the decode of the next state
  logic       mo_stall_q, mo_stall_d;
  logic       mo_bubble_q, mo_bubble_d;
  logic [1:0] ftc_q, ftc_d;
  logic [1:0] ftr_q, ftr_d;
  logic [1:0] fti_q, fti_d;
  logic [1:0] epp_q, epp_d;

  assign hazard     = ex_mr & ((dec_use1 & (dec_src1 == ex_rd)) |
                               (dec_use2 & (dec_src2 == ex_rd)));
  assign flush_idle = (flush_q == 2'd0);

  // Next state, flush counter and pending-interrupt bit; branch is the oldest event and wins
  always_comb begin
    state_d    = state_q;
    flush_d    = flush_idle ? 2'd0 : flush_q - 2'd1;
    pend_d     = pend_q | intr_req;
    ack_d      = 1'b0;
    load_use_c = 1'b0;
    if (ex_branch_taken) begin
      flush_d = FLUSH_LD;
      state_d = IDLE;
      // an aborted interrupt sequence must be replayed once the flush drains
      if (state_q == INT_FLAGS || state_q == INT_HI || state_q == INT_LO) pend_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // the decode slot is invalid while a flush is in progress
          if (flush_idle) begin
            if (pend_q) begin
              state_d = INT_FLAGS;
              ack_d   = 1'b1;
              pend_d  = 1'b0;
            end else if (dec_call) begin
              state_d = CALL_HI;
            end else if (dec_ret) begin
              state_d = RET_HI;
            end else if (hazard) begin
              load_use_c = 1'b1;
            end
          end
        end
        CALL_HI:   state_d = CALL_LO;
        CALL_LO:   state_d = IDLE;
        RET_HI:    state_d = RET_LO;
        RET_LO:    state_d = RET_WAIT;
        RET_WAIT:  state_d = IDLE;
        INT_FLAGS: state_d = INT_HI;
        INT_HI:    state_d = INT_LO;
        INT_LO:    state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Phase decode of the next state; the final phase of each sequence lets its op flow through the pipe
  always_comb begin
    mo_stall_d  = 1'b1;
    mo_bubble_d = 1'b1;
    ftc_d       = 2'b00;
    ftr_d       = 2'b00;
    fti_d       = 2'b00;
    epp_d       = PP_NONE;
    case (state_d)
      CALL_HI:   begin ftc_d = 2'b01; epp_d = PP_PUSH; end
      CALL_LO:   begin ftc_d = 2'b10; epp_d = PP_PUSH; mo_bubble_d = 1'b0; end
      RET_HI:    begin ftr_d = 2'b01; epp_d = PP_POP;  end
      RET_LO:    begin ftr_d = 2'b10; epp_d = PP_POP;  end
      RET_WAIT:  begin ftr_d = 2'b11; mo_bubble_d = 1'b0; end
      INT_FLAGS: begin fti_d = 2'b01; epp_d = PP_PUSH; end
      INT_HI:    begin fti_d = 2'b10; epp_d = PP_PUSH; end
      INT_LO:    begin fti_d = 2'b11; epp_d = PP_PUSH; mo_bubble_d = 1'b0; end
      default:   begin mo_stall_d = 1'b0; mo_bubble_d = 1'b0; end
    endcase
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      flush_q     <= 2'd0;
      pend_q      <= 1'b0;
      int_ack     <= 1'b0;
      mo_stall_q  <= 1'b0;
      mo_bubble_q <= 1'b0;
      ftc_q       <= 2'b00;
      ftr_q       <= 2'b00;
      fti_q       <= 2'b00;
      epp_q       <= PP_NONE;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      pend_q      <= pend_d;
      int_ack     <= ack_d;
      mo_stall_q  <= mo_stall_d;
      mo_bubble_q <= mo_bubble_d;
      ftc_q       <= ftc_d;
      ftr_q       <= ftr_d;
      fti_q       <= fti_d;
      epp_q       <= epp_d;
    end
  end

  // The load-use stall is the only combinational path; mask it so reset forces every output low
  logic load_use;
  assign load_use        = load_use_c & reset;

  assign pc_stall        = mo_stall_q | load_use;
  assign fd_stall        = mo_stall_q | load_use;
  assign fd_flush        = !flush_idle;
  assign de_bubble       = mo_bubble_q | !flush_idle | load_use;
  assign flash_num       = flush_q;
  assign first_time_call = ftc_q;
  assign first_time_ret  = ftr_q;
  assign first_time_int  = fti_q;
  assign enable_push_pop = epp_q;
  assign busy            = (state_q != IDLE) | !flush_idle;

endmodule

// File: tb/tb_de_pipeline_controller.sv
// Purpose: directed bench for de_pipeline_controller (load-use, flush, CALL/RET/INT, collisions, reset).
// Latency: inputs driven 2 time units after each rising edge, outputs sampled 1 unit later.
// Backpressure: none; every scenario is a fixed cycle script.
module tb_de_pipeline_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dec_call, dec_ret, dec_use1, dec_use2, ex_mr, ex_branch_taken, intr_req;
  logic [2:0] dec_src1, dec_src2, ex_rd;
  logic       pc_stall, fd_stall, fd_flush, de_bubble, int_ack, busy;
  logic [1:0] flash_num, first_time_call, first_time_ret, first_time_int, enable_push_pop;

  int n_checks = 0;
  int n_pass   = 0;

  de_pipeline_controller #(.FLUSH_CYCLES(2), .REG_W(3)) dut (
    .clk(clk), .reset(reset),
    .dec_call(dec_call), .dec_ret(dec_ret),
    .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_use1(dec_use1), .dec_use2(dec_use2),
    .ex_mr(ex_mr), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .intr_req(intr_req),
    .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush), .de_bubble(de_bubble),
    .flash_num(flash_num), .first_time_call(first_time_call), .first_time_ret(first_time_ret),
    .first_time_int(first_time_int), .enable_push_pop(enable_push_pop),
    .int_ack(int_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the script");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // field order: pc_stall fd_stall fd_flush de_bubble flash_num ftc ftr fti epp int_ack busy
  task automatic expect_out(input string tag, input logic pcs, input logic fds, input logic fl,
                            input logic bub, input logic [1:0] fn, input logic [1:0] ftc,
                            input logic [1:0] ftr, input logic [1:0] fti, input logic [1:0] epp,
                            input logic ack, input logic bsy);
    check(tag,
          {pc_stall, fd_stall, fd_flush, de_bubble, flash_num, first_time_call, first_time_ret,
           first_time_int, enable_push_pop, int_ack, busy},
          {pcs, fds, fl, bub, fn, ftc, ftr, fti, epp, ack, bsy});
  endtask

  task automatic expect_zero(input string tag);
    expect_out(tag, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
  endtask

  task automatic expect_flush(input string tag, input logic [1:0] fn);
    expect_out(tag, 0, 0, 1, 1, fn, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic call, input logic ret, input logic [2:0] s1, input logic [2:0] s2,
                       input logic u1, input logic u2, input logic mr, input logic [2:0] rd,
                       input logic br, input logic irq);
    dec_call = call; dec_ret = ret; dec_src1 = s1; dec_src2 = s2;
    dec_use1 = u1; dec_use2 = u2; ex_mr = mr; ex_rd = rd;
    ex_branch_taken = br; intr_req = irq;
    #1;
  endtask

  task automatic quiet();
    drive(0, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0);
  endtask

  initial begin
    quiet();
    reset = 1'b0;
    #1;
    expect_zero("reset_initial");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // load-use hazards
    next_cycle(); drive(0, 0, 3'd3, 3'd0, 1, 0, 1, 3'd3, 0, 0);
    expect_out("loaduse_src1", 1, 1, 0, 1, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    next_cycle(); quiet();                                   expect_zero("loaduse_one_cycle");
    next_cycle(); drive(0, 0, 3'd3, 3'd0, 0, 0, 1, 3'd3, 0, 0); expect_zero("loaduse_unused_src");
    next_cycle(); drive(0, 0, 3'd1, 3'd5, 1, 1, 1, 3'd5, 0, 0);
    expect_out("loaduse_src2", 1, 1, 0, 1, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    next_cycle(); drive(0, 0, 3'd5, 3'd5, 1, 1, 0, 3'd5, 0, 0); expect_zero("loaduse_not_load");

    // branch flush, then reload in the middle
    next_cycle(); drive(0, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 0); expect_zero("branch_cycle");
    next_cycle(); quiet();                                   expect_flush("flush_2", 2'd2);
    next_cycle(); quiet();                                   expect_flush("flush_1", 2'd1);
    next_cycle(); quiet();                                   expect_zero("flush_done");
    next_cycle(); drive(0, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 0); expect_zero("branch2_cycle");
    next_cycle(); drive(0, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 0); expect_flush("reload_first", 2'd2);
    next_cycle(); quiet();                                   expect_flush("reload_to_2", 2'd2);
    next_cycle(); drive(1, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0); expect_flush("call_in_flush", 2'd1);
    next_cycle(); quiet();                                   expect_zero("call_ignored");

    // CALL sequence
    next_cycle(); drive(1, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0); expect_zero("call_decode");
    next_cycle(); quiet();
    expect_out("call_hi", 1, 1, 0, 1, 2'd0, 2'b01, 2'b00, 2'b00, 2'b01, 0, 1);
    next_cycle(); quiet();
    expect_out("call_lo", 1, 1, 0, 0, 2'd0, 2'b10, 2'b00, 2'b00, 2'b01, 0, 1);
    next_cycle(); quiet();                                   expect_zero("call_done");

    // RET sequence with an interrupt arriving in RET_HI
    next_cycle(); drive(0, 1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0); expect_zero("ret_decode");
    next_cycle(); drive(0, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1);
    expect_out("ret_hi", 1, 1, 0, 1, 2'd0, 2'b00, 2'b01, 2'b00, 2'b10, 0, 1);
    next_cycle(); quiet();
    expect_out("ret_lo", 1, 1, 0, 1, 2'd0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1);
    next_cycle(); quiet();
    expect_out("ret_wait", 1, 1, 0, 0, 2'd0, 2'b00, 2'b11, 2'b00, 2'b00, 0, 1);
    next_cycle(); quiet();                                   expect_zero("ret_done_int_pending");
    next_cycle(); quiet();
    expect_out("int_flags", 1, 1, 0, 1, 2'd0, 2'b00, 2'b00, 2'b01, 2'b01, 1, 1);
    next_cycle(); quiet();
    expect_out("int_hi", 1, 1, 0, 1, 2'd0, 2'b00, 2'b00, 2'b10, 2'b01, 0, 1);
    next_cycle(); quiet();
    expect_out("int_lo", 1, 1, 0, 0, 2'd0, 2'b00, 2'b00, 2'b11, 2'b01, 0, 1);
    next_cycle(); quiet();                                   expect_zero("int_done");

    // two interrupt pulses during a CALL merge into one INT sequence
    next_cycle(); drive(1, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0); expect_zero("merge_call_decode");
    next_cycle(); drive(0, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1);
    expect_out("merge_call_hi", 1, 1, 0, 1, 2'd0, 2'b01, 2'b00, 2'b00, 2'b01, 0, 1);
    next_cycle(); drive(0, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1);
    expect_out("merge_call_lo", 1, 1, 0, 0, 2'd0, 2'b10, 2'b00, 2'b00, 2'b01, 0, 1);
    next_cycle(); quiet();                                   expect_zero("merge_idle");
    next_cycle(); quiet();
    expect_out("merge_int_flags", 1, 1, 0, 1, 2'd0, 2'b00, 2'b00, 2'b01, 2'b01, 1, 1);
    next_cycle(); quiet();
    expect_out("merge_int_hi", 1, 1, 0, 1, 2'd0, 2'b00, 2'b00, 2'b10, 2'b01, 0, 1);
    next_cycle(); quiet();
    expect_out("merge_int_lo", 1, 1, 0, 0, 2'd0, 2'b00, 2'b00, 2'b11, 2'b01, 0, 1);
    next_cycle(); quiet();                                   expect_zero("merge_done");
    next_cycle(); quiet();                                   expect_zero("merge_no_second_int");

    // branch collides with INT_HI: abort, flush, then the INT restarts
    next_cycle(); drive(0, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1); expect_zero("coll_irq");
    next_cycle(); quiet();                                   expect_zero("coll_pending");
    next_cycle(); quiet();
    expect_out("coll_int_flags", 1, 1, 0, 1, 2'd0, 2'b00, 2'b00, 2'b01, 2'b01, 1, 1);
    next_cycle(); drive(0, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 0);
    expect_out("coll_int_hi", 1, 1, 0, 1, 2'd0, 2'b00, 2'b00, 2'b10, 2'b01, 0, 1);
    next_cycle(); quiet();                                   expect_flush("coll_flush_2", 2'd2);
    next_cycle(); quiet();                                   expect_flush("coll_flush_1", 2'd1);
    next_cycle(); quiet();                                   expect_zero("coll_idle");
    next_cycle(); quiet();
    expect_out("coll_int_restart", 1, 1, 0, 1, 2'd0, 2'b00, 2'b00, 2'b01, 2'b01, 1, 1);
    next_cycle(); quiet();
    expect_out("coll_int_hi2", 1, 1, 0, 1, 2'd0, 2'b00, 2'b00, 2'b10, 2'b01, 0, 1);
    next_cycle(); quiet();
    expect_out("coll_int_lo2", 1, 1, 0, 0, 2'd0, 2'b00, 2'b00, 2'b11, 2'b01, 0, 1);
    next_cycle(); quiet();                                   expect_zero("coll_done");

    // asynchronous reset in CALL_LO, with a load-use hazard on the inputs
    next_cycle(); drive(1, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0); expect_zero("rst_call_decode");
    next_cycle(); quiet();
    expect_out("rst_call_hi", 1, 1, 0, 1, 2'd0, 2'b01, 2'b00, 2'b00, 2'b01, 0, 1);
    next_cycle(); quiet();
    expect_out("rst_call_lo", 1, 1, 0, 0, 2'd0, 2'b10, 2'b00, 2'b00, 2'b01, 0, 1);
    reset = 1'b0;
    drive(0, 0, 3'd2, 3'd0, 1, 0, 1, 3'd2, 0, 0);
    expect_zero("rst_async");
    @(posedge clk);
    #2;
    expect_zero("rst_held");
    @(negedge clk);
    reset = 1'b1;
    quiet();
    expect_zero("rst_release");
    next_cycle(); quiet();                                   expect_zero("rst_stays_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
